// File: rtl/jtag_tap_driver_pkg.sv
// Shared types and TMS patterns for the JTAG TAP initiator.
package jtag_tap_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RESP,
    ST_RST
  } drv_state_t;

  // TMS patterns are stored LSB-first, bit 0 goes out on the first TCK.
  localparam logic [2:0] DR_PRE        = 3'b001;
  localparam logic [3:0] IR_PRE        = 4'b0011;
  localparam logic [1:0] POST          = 2'b01;
  localparam int         RESET_SEQ_LEN = 6;

  function automatic logic pre_tms(input logic ir, input logic [1:0] idx);
    logic [3:0] pat;
    pat = ir ? IR_PRE : {1'b0, DR_PRE};
    return pat[idx];
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: TCK_DIV cycles low then TCK_DIV high while enabled, parked low otherwise.
// Strobes mark the system-clock edge that drives TCK 0->1 (rise) or 1->0 (fall).
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tck,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int               CNT_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tck;
  logic             w_wrap;

  assign w_wrap     = i_en && (r_cnt == CNT_MAX);
  assign o_rise_stb = w_wrap && !r_tck;
  assign o_fall_stb = w_wrap && r_tck;
  assign o_tck      = r_tck;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_tap_driver.sv
// JTAG initiator: runs one IR/DR scan per command from Run-Test/Idle and returns captured TDO.
// JTAG_TAP_DRIVER_RESET_SEQ_EN adds a Test-Logic-Reset -> Run-Test/Idle walk after reset.
module jtag_tap_driver
  import jtag_tap_driver_pkg::*;
#(
  parameter int TCK_DIV = 2,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_ir_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               tck_pad_o,
  output logic               tms_pad_o,
  output logic               tdi_pad_o,
  input  logic               tdo_pad_i
);

  localparam int               IDX_W   = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(RESET_SEQ_LEN - 1);

  drv_state_t         r_state;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic               r_ir;
  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_rsp;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic               r_tms;
  logic               r_tdi;

  logic               w_tck_en;
  logic               w_rise;
  logic               w_fall;
  logic               w_last;
  logic [LEN_W-1:0]   w_pre_last;
  logic [LEN_W-1:0]   w_len_clamp;
  drv_state_t         w_nxt_state;
  logic [LEN_W-1:0]   w_nxt_cnt;
  logic               w_nxt_tms;
  logic               w_nxt_tdi;

  assign w_tck_en    = (r_state == ST_PRE) || (r_state == ST_SHIFT) ||
                       (r_state == ST_POST) || (r_state == ST_RST);
  assign w_len_clamp = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
  assign w_pre_last  = r_ir ? LEN_W'(3) : LEN_W'(2);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_en       (w_tck_en),
    .o_tck      (tck_pad_o),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  // Which TCK follows the current one; only consumed on a fall strobe.
  always_comb begin
    w_last      = 1'b0;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 1'b1;
    case (r_state)
      ST_RST: begin
        w_last = (r_cnt == RST_LAST);
        if (w_last) w_nxt_state = ST_IDLE;
      end
      ST_PRE: begin
        w_last = (r_cnt == w_pre_last);
        if (w_last) w_nxt_state = (r_len == '0) ? ST_POST : ST_SHIFT;
      end
      ST_SHIFT: begin
        w_last = (r_cnt == r_len - 1'b1);
        if (w_last) w_nxt_state = ST_POST;
      end
      ST_POST: begin
        w_last = (r_cnt == LEN_W'(1));
        if (w_last) w_nxt_state = ST_RESP;
      end
      default: w_last = 1'b0;
    endcase
    if (w_last) w_nxt_cnt = '0;
  end

  // Pin levels for the upcoming TCK; a zero-length scan leaves Capture straight to Exit1.
  always_comb begin
    w_nxt_tms = 1'b0;
    w_nxt_tdi = 1'b0;
    case (w_nxt_state)
      ST_RST:   w_nxt_tms = (w_nxt_cnt != RST_LAST);
      ST_PRE:   w_nxt_tms = pre_tms(r_ir, w_nxt_cnt[1:0]) |
                            ((r_len == '0) && (w_nxt_cnt == w_pre_last));
      ST_SHIFT: begin
        w_nxt_tms = (w_nxt_cnt == r_len - 1'b1);
        w_nxt_tdi = r_data[w_nxt_cnt[IDX_W-1:0]];
      end
      ST_POST:  w_nxt_tms = POST[w_nxt_cnt[0]];
      default:  w_nxt_tms = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
`ifdef JTAG_TAP_DRIVER_RESET_SEQ_EN
      r_state <= ST_RST;
      r_tms   <= 1'b1;
`else
      r_state <= ST_IDLE;
      r_tms   <= 1'b0;
`endif
      r_cnt       <= '0;
      r_len       <= '0;
      r_ir        <= 1'b0;
      r_data      <= '0;
      r_rsp       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_tdi       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_cmd_ready && cmd_valid_i) begin
            r_state     <= ST_PRE;
            r_cnt       <= '0;
            r_ir        <= cmd_ir_i;
            r_len       <= w_len_clamp;
            r_data      <= cmd_data_i;
            r_rsp       <= '0;
            r_cmd_ready <= 1'b0;
            r_tms       <= pre_tms(cmd_ir_i, 2'd0);
            r_tdi       <= 1'b0;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          if (w_rise && (r_state == ST_SHIFT)) r_rsp[r_cnt[IDX_W-1:0]] <= tdo_pad_i;
          if (w_fall) begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_tms   <= w_nxt_tms;
            r_tdi   <= w_nxt_tdi;
            if (w_nxt_state == ST_RESP) r_rsp_valid <= 1'b1;
            if (w_nxt_state == ST_IDLE) r_cmd_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp;
  assign tms_pad_o   = r_tms;
  assign tdi_pad_o   = r_tdi;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver against a behavioural TAP (4-bit IR capturing 0001, 1-bit bypass DR).
`timescale 1ns/1ps
module tb_jtag_tap_driver;

  localparam int DIV     = 2;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int LOG_N   = 8192;
  localparam logic [3:0] IR_CAP = 4'b0001;

  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
  localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

`ifdef JTAG_TAP_DRIVER_RESET_SEQ_EN
  localparam int   RDY_LAT = 12 * DIV;
  localparam logic RST_TMS = 1'b1;
`else
  localparam int   RDY_LAT = 1;
  localparam logic RST_TMS = 1'b0;
`endif

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_i = 1'b1;
  logic               cmd_valid_i = 1'b0;
  logic               cmd_ready_o;
  logic               cmd_ir_i = 1'b0;
  logic [LEN_W-1:0]   cmd_len_i = '0;
  logic [MAX_LEN-1:0] cmd_data_i = '0;
  logic               rsp_valid_o;
  logic               rsp_ready_i = 1'b0;
  logic [MAX_LEN-1:0] rsp_data_o;
  logic               tck_pad_o;
  logic               tms_pad_o;
  logic               tdi_pad_o;
  logic               tdo_pad_i = 1'b0;

  jtag_tap_driver #(.TCK_DIV(DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_ir_i    (cmd_ir_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_data_i  (cmd_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .tck_pad_o   (tck_pad_o),
    .tms_pad_o   (tms_pad_o),
    .tdi_pad_o   (tdi_pad_o),
    .tdo_pad_i   (tdo_pad_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- behavioural TAP + pin log ----------------
  int         tap_st = RTI;
  int         trst_state = RTI;
  logic       tap_trst = 1'b0;
  logic       dr_bit = 1'b0;
  logic [3:0] ir_sr = 4'b0;
  logic [3:0] ir_reg = 4'b0;
  int         rec_n = 0;
  logic       tms_log [LOG_N];
  logic       tdi_log [LOG_N];

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:       return m ? TLR  : RTI;
      RTI:       return m ? SDR  : RTI;
      SDR:       return m ? SIR  : CDR;
      CDR, SHDR: return m ? E1DR : SHDR;
      E1DR:      return m ? UDR  : PDR;
      PDR:       return m ? E2DR : PDR;
      E2DR:      return m ? UDR  : SHDR;
      UDR, UIR:  return m ? SDR  : RTI;
      SIR:       return m ? TLR  : CIR;
      CIR, SHIR: return m ? E1IR : SHIR;
      E1IR:      return m ? UIR  : PIR;
      PIR:       return m ? E2IR : PIR;
      E2IR:      return m ? UIR  : SHIR;
      default:   return TLR;
    endcase
  endfunction

  always @(posedge tck_pad_o or posedge tap_trst) begin
    if (tap_trst) begin
      tap_st = trst_state;
    end else begin
      if (rec_n < LOG_N) begin
        tms_log[rec_n] = tms_pad_o;
        tdi_log[rec_n] = tdi_pad_o;
      end
      rec_n++;
      case (tap_st)
        CDR:     dr_bit = 1'b0;
        SHDR:    dr_bit = tdi_pad_o;
        CIR:     ir_sr  = IR_CAP;
        SHIR:    ir_sr  = {tdi_pad_o, ir_sr[3:1]};
        UIR:     ir_reg = ir_sr;
        default: ;
      endcase
      tap_st = tap_next(tap_st, tms_pad_o);
    end
  end

  always @(negedge tck_pad_o)
    tdo_pad_i = (tap_st == SHDR) ? dr_bit : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

  // ---------------- reference model ----------------
  // Scan output stream: the TAP register's captured bits first, then the TDI data shifted through it.
  function automatic logic stream_bit(input logic ir, input logic [63:0] data, input int j);
    int         w;
    logic [3:0] cap;
    w   = ir ? 4 : 1;
    cap = ir ? IR_CAP : 4'b0;
    if (j < w) return cap[j];
    return data[j - w];
  endfunction

  function automatic logic [127:0] exp_tms(input logic ir, input int n);
    logic [127:0] v;
    int p;
    v = '0;
    v[0] = 1'b1;
    p = 1;
    if (ir) begin v[1] = 1'b1; p = 2; end
    v[p] = 1'b0;
    v[p+1] = (n == 0);
    p = p + 2;
    for (int i = 0; i < n; i++) v[p+i] = (i == n - 1);
    p = p + n;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] exp_tdi(input logic ir, input int n, input logic [63:0] data);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[(ir ? 4 : 3) + i] = data[i];
    return v;
  endfunction

  task automatic pulse_trst();
    tap_trst = 1'b1;
    #1;
    tap_trst = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    int cyc, base;
    logic [5:0] seq;
    wb_rst_i = 1'b1;
    #1;
    check({tag, ":rst_pins"}, {cmd_ready_o, rsp_valid_o, tck_pad_o, tms_pad_o, tdi_pad_o},
          {4'b0000, RST_TMS});
    check({tag, ":rst_data"}, rsp_data_o, 0);
    repeat (3) @(posedge wb_clk_i);
    #2;
    base = rec_n;
    wb_rst_i = 1'b0;
    cyc = 0;
    while (!cmd_ready_o && cyc < 400) begin
      @(posedge wb_clk_i); #1; cyc++;
    end
    check({tag, ":ready_lat"}, cyc, RDY_LAT);
`ifdef JTAG_TAP_DRIVER_RESET_SEQ_EN
    seq = '0;
    for (int i = 0; i < 6; i++) seq[i] = tms_log[base + i];
    check({tag, ":seq_tcks"}, rec_n - base, 6);
    check({tag, ":seq_tms"}, seq, 6'b011111);
    check({tag, ":seq_rti"}, tap_st, RTI);
`else
    seq = '0;
    check({tag, ":no_tck"}, {seq, rec_n - base}, 0);
`endif
  endtask

  task automatic run_scan(input logic ir, input int len, input logic [63:0] data, input int hold,
                          input logic [63:0] exp_rsp, input int exp_tcks, input string tag);
    int cyc, base, n, hb;
    logic [127:0] g_tms, g_tdi;
    logic [3:0] e_ir;
    logic ok;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    cyc = 0;
    while (!cmd_ready_o && cyc < 100) begin
      @(posedge wb_clk_i); #1; cyc++;
    end
    check({tag, ":ready"}, cmd_ready_o, 1);
    base = rec_n;
    cmd_valid_i = 1'b1;
    cmd_ir_i    = ir;
    cmd_len_i   = len[LEN_W-1:0];
    cmd_data_i  = data;
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b0;
    check({tag, ":accept_drop"}, cmd_ready_o, 0);
    cyc = 0;
    while (!rsp_valid_o && cyc < 2000) begin
      @(posedge wb_clk_i); #1; cyc++;
    end
    check({tag, ":latency"}, cyc, 2 * DIV * exp_tcks);
    check({tag, ":rsp"}, rsp_data_o, exp_rsp);
    check({tag, ":tcks"}, rec_n - base, exp_tcks);
    g_tms = '0;
    g_tdi = '0;
    for (int i = 0; i < exp_tcks && i < 128; i++) begin
      g_tms[i] = tms_log[base + i];
      g_tdi[i] = tdi_log[base + i];
    end
    check({tag, ":tms"}, g_tms, exp_tms(ir, n));
    check({tag, ":tdi"}, g_tdi, exp_tdi(ir, n, data));
    check({tag, ":tap_rti"}, tap_st, RTI);
    if (ir) begin
      for (int k = 0; k < 4; k++) e_ir[k] = stream_bit(1'b1, data, k + n);
      check({tag, ":tap_ir"}, ir_reg, e_ir);
    end
    if (hold > 0) begin
      hb = rec_n;
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        cmd_valid_i = (i == hold / 2);
        @(posedge wb_clk_i); #1;
        if (!(rsp_valid_o && !cmd_ready_o && rsp_data_o == exp_rsp)) ok = 1'b0;
      end
      cmd_valid_i = 1'b0;
      check({tag, ":hold"}, ok, 1);
      check({tag, ":busy_no_tck"}, rec_n - hb, 0);
    end
    rsp_ready_i = 1'b1;
    @(posedge wb_clk_i); #1;
    rsp_ready_i = 1'b0;
    check({tag, ":handshake"}, {rsp_valid_o, cmd_ready_o}, 2'b01);
    check({tag, ":rsp_keep"}, rsp_data_o, exp_rsp);
  endtask

  typedef struct {
    logic        ir;
    int          len;
    logic [63:0] data;
    int          hold;
    logic [63:0] exp_rsp;
    int          exp_tcks;
  } vec_t;

  vec_t        vecs [6];
  logic        r_ir;
  int          r_len, r_n;
  logic [63:0] r_data, r_exp;

  initial begin
    vecs[0] = '{1'b0,   8, 64'hA5,                  0, 64'h4A,                  13};
    vecs[1] = '{1'b1,   4, 64'h8,                   0, 64'h1,                   10};
    vecs[2] = '{1'b0,   0, 64'hFF,                  0, 64'h0,                    5};
    vecs[3] = '{1'b0, 100, 64'hDEADBEEF_01234567,   0, 64'hBD5B7DDE_02468ACE,   69};
    vecs[4] = '{1'b0,  16, 64'h1234,               10, 64'h2468,                21};
    vecs[5] = '{1'b1,   6, 64'h2B,                  0, 64'h31,                  12};

`ifdef JTAG_TAP_DRIVER_RESET_SEQ_EN
    trst_state = SHDR;
`else
    trst_state = RTI;
`endif
    pulse_trst();
    do_reset("por");

    for (int v = 0; v < 6; v++)
      run_scan(vecs[v].ir, vecs[v].len, vecs[v].data, vecs[v].hold,
               vecs[v].exp_rsp, vecs[v].exp_tcks, $sformatf("vec%0d", v));

    // Abandon a DR scan during its sixth TCK, then recover.
    begin
      int base, cyc;
      cmd_valid_i = 1'b1; cmd_ir_i = 1'b0; cmd_len_i = 7'd8; cmd_data_i = 64'hA5;
      base = rec_n;
      @(posedge wb_clk_i); #1;
      cmd_valid_i = 1'b0;
      cyc = 0;
      while (rec_n - base < 5 && cyc < 200) begin
        @(posedge wb_clk_i); #1; cyc++;
      end
      repeat (DIV + 1) @(posedge wb_clk_i);
      #1;
      check("midrst:tck5_reached", rec_n - base, 5);
`ifndef JTAG_TAP_DRIVER_RESET_SEQ_EN
      trst_state = RTI;
      pulse_trst();
`endif
      do_reset("midrst");
      run_scan(1'b0, 8, 64'hA5, 0, 64'h4A, 13, "post_rst");
    end

    for (int k = 0; k < 12; k++) begin
      r_ir   = 1'($urandom_range(0, 1));
      r_len  = int'($urandom_range(0, 70));
      r_data = {$urandom, $urandom};
      r_n    = (r_len > MAX_LEN) ? MAX_LEN : r_len;
      r_exp  = '0;
      for (int i = 0; i < r_n; i++) r_exp[i] = stream_bit(r_ir, r_data, i);
      run_scan(r_ir, r_len, r_data, int'($urandom_range(0, 3)), r_exp,
               r_n + (r_ir ? 6 : 5), $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
- Synthesizable JTAG initiator: drives tck/tms/tdi into an orpsoc_multi_top TAP and samples tdo.
- Complements the DUT-side TAP and debug interface, which today is only a responder with floating pins.
- Accepts IR/DR shift commands of 0..64 bits over a valid/ready interface and returns the captured TDO bits.
- Sits in the bench or in an on-chip debug bridge, clocked from wb_clk_i.

Parameters:
TCK_DIV, 2, TCK half-period in wb_clk_i cycles (>=1)
MAX_LEN, 64, maximum shift length in bits
LEN_W, 7, width of length field

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  driver idle in Run-Test/Idle, command acceptable
cmd_ir_i  in  1  1=IR scan, 0=DR scan
cmd_len_i  in  LEN_W  bits to shift (0..MAX_LEN; larger clamped to MAX_LEN)
cmd_data_i  in  MAX_LEN  TDI data, LSB shifted first
rsp_valid_o  out  1  scan complete, rsp_data_o valid
rsp_ready_i  in  1  response consumed
rsp_data_o  out  MAX_LEN  captured TDO, first bit at [0], bits >= len zero
tck_pad_o  out  1  JTAG TCK
tms_pad_o  out  1  JTAG TMS
tdi_pad_o  out  1  JTAG TDI
tdo_pad_i  in  1  JTAG TDO

Behaviour:
- Reset values: cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, tck_pad_o=0, tms_pad_o=0, tdi_pad_o=0.
- cmd_ready_o rises on the first wb_clk_i edge after reset deasserts.
- Command accept: cmd_valid_i & cmd_ready_o on a rising edge; latch ir, clamped len, data; cmd_ready_o drops the same edge.
- TCK timing:
  - One TCK = TCK_DIV cycles low, then TCK_DIV cycles high; idles low.
  - tms/tdi update at the start of the low phase; tdo sampled on the wb_clk edge that drives tck_pad_o 0->1.
- States: IDLE, PRE, SHIFT, POST, RESP.
- TMS sequence from Run-Test/Idle:
  - DR: PRE 1,0,0; SHIFT N bits, TMS=0 except the last bit =1; POST 1,0.
  - IR: PRE 1,1,0,0; SHIFT as DR; POST 1,0.
  - N=0: the last PRE TMS becomes 1 (Capture->Exit1). SHIFT is skipped, no tdo sampled, rsp_data_o=0.
  - Totals: DR N+5 TCKs, IR N+6 TCKs.
- tdi_pad_o=data[i] during shift bit i. Sampled tdo goes to rsp_data_o[i]. tdi is 0 outside SHIFT.
- rsp_valid_o rises on the edge ending the last TCK high phase, i.e. 2*TCK_DIV*(total TCKs) cycles after accept.
- Response hold: rsp_valid_o and rsp_data_o hold until rsp_valid_o & rsp_ready_i.
- cmd_ready_o rises the edge after that handshake; rsp_data_o keeps its value until the next accept.
- cmd_valid_i while busy is ignored, not queued.
- Reset mid-scan: all outputs return to reset values immediately (async) and the scan is abandoned. The TAP state is then undefined unless the optional feature is compiled in.

Optional Feature:
- Macro JTAG_TAP_DRIVER_RESET_SEQ_EN.
- Defined:
  - tms_pad_o resets to 1.
  - After reset deasserts, emit 5 TCKs with TMS=1 (Test-Logic-Reset), then 1 TCK with TMS=0 (Run-Test/Idle).
  - cmd_ready_o rises on the edge ending that sequence: 12*TCK_DIV cycles after deassert.
- Undefined: no sequence; the TAP is required to already be in Run-Test/Idle.

Decomposition:
- Package jtag_tap_driver_pkg: driver state enum; PRE/POST TMS constants (DR_PRE=3'b001 LSB-first, IR_PRE=4'b0011, POST=2'b01); RESET_SEQ_LEN=6.
- Sub-module jtag_tck_gen: TCK_DIV counter producing tck level plus single-cycle fall_stb/rise_stb enables; runs only when enabled by the FSM.

Test Plan:
- Reset, macro off: all outputs 0 during reset; cmd_ready_o=1 one cycle after deassert; no TCK edges.
- DR, len=8, data=0xA5, TCK_DIV=2, bypass TAP model (1-bit register, captures 0) -> 13 TCK rises; TMS 1,0,0,0x7,1,1,0; rsp_data_o=0x4A; rsp_valid_o rises 52 cycles after accept.
- IR, len=4, data=0x8, TAP model IR capture 4'b0001 -> 10 TCKs; TMS 1,1,0,0,0,0,0,1,1,0; tdi bits 0,0,0,1; rsp_data_o=0x1.
- DR, len=0 -> 5 TCKs; TMS 1,0,1,1,0; rsp_data_o=0. Also len=100 -> clamped to 64 shifts (69 TCKs).
- Back-pressure: rsp_ready_i low 10 cycles -> rsp_valid_o/rsp_data_o held, cmd_ready_o low; a cmd_valid_i pulse in that window produces no TCK; handshake -> cmd_ready_o=1 next cycle.
- Reset asserted during TCK 6 of a DR scan -> outputs at reset values within the same cycle; a new DR len=8 command after release completes correctly. With RESET_SEQ_EN: 6-TCK TMS 1,1,1,1,1,0 precedes cmd_ready_o.
